// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage owning the PC, an imem req/ack port and the IF/ID register.
// Latency: ack in cycle N appears on IF/ID in cycle N+1; one instruction per cycle with zero-wait memory.
// Backpressure: stall_d holds IF/ID; an ack taken under stall parks in a one-entry buffer (HOLD, no request).
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / bubble_count performance counters.
module fetch_stage #(
  parameter int                   ADDRESS_WIDTH = 32,
  parameter int                   DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic                     valid_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0]   drain_addr_q, drain_addr_d;
  logic [DATA_WIDTH-1:0]      buf_q, buf_d;
  logic [ADDRESS_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [ADDRESS_WIDTH-1:0]   ifid_pc4_q, ifid_pc4_d;
  logic [DATA_WIDTH-1:0]      ifid_instr_q, ifid_instr_d;
  logic                       ifid_vld_q, ifid_vld_d;
  logic                       ifid_load;
  logic [ADDRESS_WIDTH-1:0]   pc_plus4;
  logic [ADDRESS_WIDTH-1:0]   target_aligned;
  // Redirect targets are forced word-aligned, so the low two bits are never consumed.
  logic [1:0]                 unused_target_lsbs;

  assign pc_plus4           = pc_q + PC_STEP;
  assign target_aligned     = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = pc_target_e[1:0];

  // Memory port: HOLD parks the request, DRAIN keeps presenting the stale address until its ack.
  always_comb begin
    imem_req  = !rst && (state_q != S_HOLD);
    imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  end

  // Next-state, PC and IF/ID update; a redirect overrides stall and any ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    ifid_load    = 1'b0;

    if (pc_src_e) begin
      pc_d         = target_aligned;
      ifid_load    = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = NOP_INSTR;
      ifid_vld_d   = 1'b0;
      if (state_q == S_FETCH && !imem_ack) begin
        // Request is still in flight: remember its address so it can be drained.
        state_d      = S_DRAIN;
        drain_addr_d = pc_q;
      end else if (state_q == S_DRAIN && !imem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack && !stall_d) begin
            ifid_load    = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_vld_d   = 1'b1;
            pc_d         = pc_plus4;
          end else if (imem_ack) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else if (!stall_d) begin
            ifid_load    = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = NOP_INSTR;
            ifid_vld_d   = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            ifid_load    = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = buf_q;
            ifid_vld_d   = 1'b1;
            pc_d         = pc_plus4;
            state_d      = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            state_d = S_FETCH;
          end
          if (!stall_d) begin
            ifid_load    = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = NOP_INSTR;
            ifid_vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State registers; reset clears everything immediately, so an ack during reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      buf_q        <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign pc_f       = ifid_pc_q;
  assign pc_plus4_f = ifid_pc4_q;
  assign instr_f    = ifid_instr_q;
  assign valid_f    = ifid_vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Count every IF/ID load, split by whether it carried a real instruction; both wrap freely.
  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (ifid_load) begin
      if (ifid_vld_d) fetch_count_d  = fetch_count_q + 32'd1;
      else            bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule
